key_search_dispatcher: RTL and testbench
========================================

# key_search_dispatcher

Parametrised key-space sequencer for the RC4 brute-force path. It replaces the single-channel "increment key, check limit" controller with a dispatcher that hands consecutive secret-key candidates from a programmable range to NUM_CH parallel decrypt cores. Dispatch uses a round-robin request/acknowledge handshake. The block tracks the key each core is working on, stops on the first reported match, and flags exhaustion when the range is used up with no match.

## Interface
- KEY_W, 24: key width in bits.
- NUM_CH, 4: number of decrypt-core channels, 1..16. CH_W = max(1, clog2(NUM_CH)) is derived and not overridable.

- clk  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; loads range and begins search. Honoured only in IDLE, DONE_OK, DONE_FAIL.
- key_lo  in  KEY_W  first key of range, sampled on accepted start.
- key_hi  in  KEY_W  last key of range (inclusive), sampled on accepted start.
- req  in  NUM_CH  channel c requests a key; held high until ack[c].
- found  in  NUM_CH  one-cycle pulse; channel c's current key decrypted correctly.
- ack  out  NUM_CH  one-hot or zero, registered, one-cycle grant.
- key_out  out  KEY_W  granted key, valid while ack != 0.
- key_ch  out  CH_W  index of granted channel, valid while ack != 0.
- busy  out  1  high in RUN.
- done  out  1  high in DONE_OK or DONE_FAIL.
- success  out  1  high in DONE_OK.
- result_key  out  KEY_W  matching key, valid in DONE_OK.
- result_ch  out  CH_W  channel that found it, valid in DONE_OK.

## Operation
- States: IDLE, RUN, DONE_OK, DONE_FAIL.
- Reset (reset_n low at an edge), from any state including mid-search: state IDLE; ack, key_out, key_ch, busy, done, success, result_key, result_ch all 0; next-key counter 0; outstanding mask 0; round-robin pointer 0. Reset overrides start, req and found in the same cycle.
- Accepted start: load counter with {1'b0, key_lo} (KEY_W+1 bits so key_hi = all-ones cannot wrap). Latch key_hi. Clear outstanding and per-channel key registers. Set pointer to 0. Go to RUN. start in RUN is ignored.
- RUN, each cycle, evaluated in this priority order:
  1. Any found[c] with outstanding[c] set: the lowest such c wins. Latch result_key = chan_key[c] and result_ch = c. Go to DONE_OK. No ack this cycle. found on a channel without outstanding set is ignored.
  2. Any req[c] clears outstanding[c]. This means the previous key for that channel did not match.
  3. Arbitration considers req masked by the currently asserted ack. If counter <= key_hi and any eligible req exists, grant the first requester at or after the pointer, wrapping. Next cycle: ack[c]=1, key_out = counter[KEY_W-1:0], key_ch = c. Also set chan_key[c], set outstanding[c], counter += 1, pointer = c+1 mod NUM_CH.
  4. If counter > key_hi and no outstanding bit will remain set after this cycle's updates: go to DONE_FAIL. Requests arriving after exhaustion are never acked.
- key_lo > key_hi: RUN for exactly one cycle with no grants, then DONE_FAIL.
- DONE_OK and DONE_FAIL hold (result outputs stable, ack 0) until the next accepted start or reset.

## Timing
- start sampled at edge t: busy high from t+1. The earliest ack is at t+2, for a req present during cycle t+1.
- Grant latency: req sampled at edge n produces ack in cycle n+1 (one cycle minimum). Throughput is at most one key per cycle across all channels.
- A channel must drop req in the cycle it sees ack. A req still high in that cycle is masked and not granted twice.
- found at edge n: done and success high and busy low from n+1. ack is never asserted in the same cycle as done.
- Exhaustion: the last outstanding channel's req (or a found for it) at edge n causes done from n+1.

## Test plan
- Reset mid-RUN with req and found active: next cycle all outputs 0, state IDLE. A following start with lo=0, hi=3 restarts cleanly and the first key granted is 0.
- NUM_CH=4, lo=0x10, hi=0x17, all req held (dropped on ack, re-raised next cycle): keys 0x10..0x17 granted to channels 0,1,2,3,0,1,2,3. After all four re-request: DONE_FAIL, success=0.
- Same range, found[2] pulsed while channel 2 holds 0x16: DONE_OK, result_key=0x16, result_ch=2, no further ack.
- found[1] and found[3] in the same cycle, both outstanding: result_ch=1. found[0] with outstanding[0] clear: ignored.
- lo=hi=0xFFFFFF: exactly one grant of 0xFFFFFF, no wrap to 0, then DONE_FAIL after that channel re-requests.
- lo=5, hi=4: zero acks, done from cycle t+2. start pulsed during RUN: ignored, counter unchanged.

Source files
------------

// File: rtl/key_search_dispatcher.sv
// key_search_dispatcher
// Hands consecutive key candidates from [key_lo, key_hi] to NUM_CH decrypt
// cores over a round-robin req/ack handshake, remembers the key each core
// holds, and stops on the first reported match or when the range runs dry.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | after reset, waiting for start
// S_RUN     | dispatching keys, watching found/req
// S_DONE_OK | a core reported a match; result_key/result_ch hold it
// S_DONE_FL | range exhausted with every issued key retired, no match
module key_search_dispatcher #(
    parameter int KEY_W  = 24,
    parameter int NUM_CH = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [KEY_W-1:0]  key_lo,
    input  logic [KEY_W-1:0]  key_hi,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] found,
    output logic [NUM_CH-1:0] ack,
    output logic [KEY_W-1:0]  key_out,
    output logic [CH_W-1:0]   key_ch,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic [KEY_W-1:0]  result_key,
    output logic [CH_W-1:0]   result_ch
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_DONE_OK = 2'd2;
    localparam logic [1:0] S_DONE_FL = 2'd3;

    logic [1:0]        state_q,   state_d;
    // one extra bit so that key_hi = all-ones terminates instead of wrapping
    logic [KEY_W:0]    cnt_q,     cnt_d;
    logic [KEY_W-1:0]  hi_q,      hi_d;
    logic [NUM_CH-1:0] outst_q,   outst_d;
    logic [CH_W-1:0]   ptr_q,     ptr_d;
    logic [NUM_CH-1:0] ack_q,     ack_d;
    logic [KEY_W-1:0]  key_out_q, key_out_d;
    logic [CH_W-1:0]   key_ch_q,  key_ch_d;
    logic [KEY_W-1:0]  res_key_q, res_key_d;
    logic [CH_W-1:0]   res_ch_q,  res_ch_d;
    logic [KEY_W-1:0]  chan_key_q [NUM_CH];

    logic              chan_we;
    logic              chan_clr;
    logic [NUM_CH-1:0] found_hit;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] outst_nx;
    logic [CH_W-1:0]   hit_ch;
    logic [CH_W-1:0]   gnt_ch;
    logic              gnt_ok;
    int                rr_idx;

    assign found_hit = found & outst_q;
    // a channel still showing req during its ack cycle must not be granted twice
    assign elig      = req & ~ack_q;

    // lowest-numbered channel reporting a match on a key it actually holds
    always_comb begin
        hit_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (found_hit[i]) hit_ch = CH_W'(i);
        end
    end

    // round-robin pick: first eligible requester at or after the pointer
    always_comb begin
        gnt_ch = '0;
        gnt_ok = 1'b0;
        rr_idx = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_idx = int'(ptr_q) + i;
            if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
            if (!gnt_ok && elig[rr_idx]) begin
                gnt_ok = 1'b1;
                gnt_ch = CH_W'(rr_idx);
            end
        end
    end

    // next-state and datapath updates for the sequencer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        outst_d   = outst_q;
        ptr_d     = ptr_q;
        ack_d     = '0;
        key_out_d = key_out_q;
        key_ch_d  = key_ch_q;
        res_key_d = res_key_q;
        res_ch_d  = res_ch_q;
        chan_we   = 1'b0;
        chan_clr  = 1'b0;
        outst_nx  = outst_q & ~req;
        case (state_q)
            S_RUN: begin
                if (|found_hit) begin
                    res_key_d = chan_key_q[hit_ch];
                    res_ch_d  = hit_ch;
                    state_d   = S_DONE_OK;
                end else begin
                    if ((cnt_q <= {1'b0, hi_q}) && gnt_ok) begin
                        ack_d[gnt_ch]    = 1'b1;
                        key_out_d        = cnt_q[KEY_W-1:0];
                        key_ch_d         = gnt_ch;
                        chan_we          = 1'b1;
                        outst_nx[gnt_ch] = 1'b1;
                        cnt_d            = cnt_q + 1'b1;
                        ptr_d            = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
                    end
                    outst_d = outst_nx;
                    if ((cnt_q > {1'b0, hi_q}) && (outst_nx == '0)) begin
                        state_d = S_DONE_FL;
                    end
                end
            end
            default: begin
                if (start) begin
                    cnt_d    = {1'b0, key_lo};
                    hi_d     = key_hi;
                    outst_d  = '0;
                    chan_clr = 1'b1;
                    ptr_d    = '0;
                    state_d  = S_RUN;
                end
            end
        endcase
    end

    // control and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            outst_q   <= '0;
            ptr_q     <= '0;
            ack_q     <= '0;
            key_out_q <= '0;
            key_ch_q  <= '0;
            res_key_q <= '0;
            res_ch_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            outst_q   <= outst_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            key_out_q <= key_out_d;
            key_ch_q  <= key_ch_d;
            res_key_q <= res_key_d;
            res_ch_q  <= res_ch_d;
        end
    end

    // per-channel record of the key last handed out
    always_ff @(posedge clk) begin
        if (!reset_n || chan_clr) begin
            for (int i = 0; i < NUM_CH; i++) chan_key_q[i] <= '0;
        end else if (chan_we) begin
            chan_key_q[gnt_ch] <= cnt_q[KEY_W-1:0];
        end
    end

    assign ack        = ack_q;
    assign key_out    = key_out_q;
    assign key_ch     = key_ch_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE_OK) || (state_q == S_DONE_FL);
    assign success    = (state_q == S_DONE_OK);
    assign result_key = res_key_q;
    assign result_ch  = res_ch_q;

endmodule

// File: tb/tb_key_search_dispatcher.sv
// Bench for key_search_dispatcher: channel models drive req/found, expected
// grants are queued at start and matched as ack appears.
module tb_key_search_dispatcher;

    localparam int KEY_W  = 24;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [CH_W-1:0]  ch;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [KEY_W-1:0]  key_lo, key_hi;
    logic [NUM_CH-1:0] req, found;
    logic [NUM_CH-1:0] ack;
    logic [KEY_W-1:0]  key_out;
    logic [CH_W-1:0]   key_ch;
    logic              busy, done, success;
    logic [KEY_W-1:0]  result_key;
    logic [CH_W-1:0]   result_ch;

    exp_t              sb[$];
    logic [NUM_CH-1:0] en, rereq;
    logic              fnd_arm;
    logic [KEY_W-1:0]  fnd_key;
    int                n_vec = 0;
    int                n_err = 0;
    int                acks_seen = 0;

    key_search_dispatcher #(.KEY_W(KEY_W), .NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .key_lo     (key_lo),
        .key_hi     (key_hi),
        .req        (req),
        .found      (found),
        .ack        (ack),
        .key_out    (key_out),
        .key_ch     (key_ch),
        .busy       (busy),
        .done       (done),
        .success    (success),
        .result_key (result_key),
        .result_ch  (result_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [KEY_W-1:0] k, input int c);
        exp_t e;
        e.key = k;
        e.ch  = CH_W'(c);
        sb.push_back(e);
    endtask

    // one cycle: sample outputs at negedge, score grants, update channel models
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        found = '0;
        start = 1'b0;
        if (done) chk("no_ack_in_done", ack, 0);
        if (ack != '0) begin
            acks_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_ack", ack, 0);
            end else begin
                e = sb.pop_front();
                chk("grant_key", key_out, e.key);
                chk("grant_ch", key_ch, e.ch);
                chk("ack_onehot", ack, 32'(4'b0001 << e.ch));
            end
            if (!rereq[key_ch]) en[key_ch] = 1'b0;
            if (fnd_arm && key_out == fnd_key) begin
                found[key_ch] = 1'b1;
                fnd_arm = 1'b0;
            end
        end
        req = en & ~ack;
    endtask

    task automatic do_start(input logic [KEY_W-1:0] lo, input logic [KEY_W-1:0] hi);
        key_lo    = lo;
        key_hi    = hi;
        start     = 1'b1;
        acks_seen = 0;
        cyc();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) cyc();
        chk("done_timeout", done, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        key_lo  = '0;
        key_hi  = '0;
        req     = '0;
        found   = '0;
        en      = '0;
        rereq   = '0;
        fnd_arm = 1'b0;
        fnd_key = '0;
        repeat (3) cyc();
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_key_out", key_out, 0);
        reset_n = 1'b1;
        cyc();

        // full range, all channels re-requesting, ends in exhaustion
        en = 4'hF; rereq = 4'hF;
        for (int i = 0; i < 8; i++) push(24'h10 + KEY_W'(i), i % 4);
        do_start(24'h10, 24'h17);
        chk("busy_after_start", busy, 1);
        chk("no_ack_first_run_cycle", ack, 0);
        cyc();
        chk("first_ack_latency", ack, 4'b0001);
        wait_done(40);
        chk("A_success", success, 0);
        chk("A_acks", acks_seen, 8);
        chk("A_sb_left", sb.size(), 0);
        en = '0;
        cyc();

        // match on channel 2 holding 0x16
        en = 4'hF; rereq = 4'hF;
        fnd_key = 24'h16; fnd_arm = 1'b1;
        for (int i = 0; i < 7; i++) push(24'h10 + KEY_W'(i), i % 4);
        do_start(24'h10, 24'h17);
        wait_done(40);
        chk("B_success", success, 1);
        chk("B_busy", busy, 0);
        chk("B_result_key", result_key, 24'h16);
        chk("B_result_ch", result_ch, 2);
        chk("B_acks", acks_seen, 7);
        repeat (3) cyc();
        chk("B_result_hold", result_key, 24'h16);
        chk("B_sb_left", sb.size(), 0);
        en = '0; fnd_arm = 1'b0;
        cyc();

        // stray found ignored, simultaneous found picks lowest channel
        en = 4'b1010; rereq = 4'b0000;
        push(24'h20, 1);
        push(24'h21, 3);
        do_start(24'h20, 24'h2F);
        repeat (4) cyc();
        found = 4'b0001;
        cyc();
        chk("C_stray_found_busy", busy, 1);
        chk("C_stray_found_done", done, 0);
        found = 4'b1010;
        cyc();
        chk("C_done", done, 1);
        chk("C_success", success, 1);
        chk("C_result_ch", result_ch, 1);
        chk("C_result_key", result_key, 24'h20);
        chk("C_sb_left", sb.size(), 0);
        cyc();

        // top of key space, no wrap
        en = 4'hF; rereq = 4'hF;
        push(24'hFFFFFF, 0);
        do_start(24'hFFFFFF, 24'hFFFFFF);
        wait_done(20);
        chk("D_success", success, 0);
        chk("D_acks", acks_seen, 1);
        chk("D_sb_left", sb.size(), 0);
        en = '0;
        cyc();

        // empty range lo > hi
        en = 4'hF; rereq = 4'hF;
        do_start(24'd5, 24'd4);
        chk("E_busy_t1", busy, 1);
        chk("E_done_t1", done, 0);
        cyc();
        chk("E_done_t2", done, 1);
        chk("E_success", success, 0);
        chk("E_acks", acks_seen, 0);
        en = '0;
        cyc();

        // start during RUN is ignored
        en = 4'b0001; rereq = 4'b0001;
        for (int i = 0; i < 4; i++) push(24'h40 + KEY_W'(i), 0);
        do_start(24'h40, 24'h43);
        cyc();
        key_lo = 24'h80; key_hi = 24'h90; start = 1'b1;
        cyc();
        wait_done(30);
        chk("F_success", success, 0);
        chk("F_acks", acks_seen, 4);
        chk("F_sb_left", sb.size(), 0);
        en = '0;
        cyc();

        // reset mid-RUN with req, found and start active
        en = 4'hF; rereq = 4'hF;
        for (int i = 0; i < 8; i++) push(KEY_W'(i), i % 4);
        do_start(24'h0, 24'hFF);
        repeat (3) cyc();
        sb.delete();
        reset_n = 1'b0; found = 4'hF; start = 1'b1;
        cyc();
        chk("G_ack", ack, 0);
        chk("G_key_out", key_out, 0);
        chk("G_key_ch", key_ch, 0);
        chk("G_busy", busy, 0);
        chk("G_done", done, 0);
        chk("G_success", success, 0);
        chk("G_result_key", result_key, 0);
        chk("G_result_ch", result_ch, 0);
        reset_n = 1'b1;
        cyc();
        chk("G_idle_after_reset", busy, 0);
        for (int i = 0; i < 4; i++) push(KEY_W'(i), i);
        do_start(24'h0, 24'h3);
        wait_done(30);
        chk("G2_success", success, 0);
        chk("G2_acks", acks_seen, 4);
        chk("G2_sb_left", sb.size(), 0);
        en = '0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
